// File: rtl/bus_pkg.sv
// Shared bus types and region map for the manager-side address router.
package bus_pkg;

  localparam logic [7:0] S0_BASE     = 8'h00;
  localparam logic [7:0] S1_BASE     = 8'h40;
  localparam logic [7:0] REGION_SIZE = 8'h40;

  typedef enum logic {
    RESP_OK  = 1'b0,
    RESP_ERR = 1'b1
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    ERR,
    DONE
  } router_state_t;

  typedef enum logic [1:0] {
    SEL_S0   = 2'd0,
    SEL_S1   = 2'd1,
    SEL_NONE = 2'd2
  } sel_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: one base/size window per slave, lowest index wins.
module bus_addr_decode #(
  parameter int                      ADDR_W = 8,
  parameter int                      NUM    = 2,
  parameter logic [NUM*ADDR_W-1:0]   BASES  = {8'h40, 8'h00},
  parameter logic [ADDR_W-1:0]       SIZE   = 8'h40
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output bus_pkg::sel_t     sel
);
  import bus_pkg::*;

  logic [NUM-1:0] hit_vec;

  // One extra bit keeps base+size from wrapping, so there is no aliasing at the top of the map.
  for (genvar gi = 0; gi < NUM; gi++) begin : g_region
    localparam logic [ADDR_W:0] LO = {1'b0, BASES[gi*ADDR_W +: ADDR_W]};
    localparam logic [ADDR_W:0] HI = LO + {1'b0, SIZE};
    assign hit_vec[gi] = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
  end

  always_comb begin
    hit = |hit_vec;
    sel = SEL_NONE;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) sel = sel_t'(i[1:0]);
    end
  end

endmodule

// File: rtl/bus_addr_router.sv
// Routes one manager request at a time to slave 0/1 by address; unmapped or
// unresponsive targets complete with an error so the manager never stalls.
module bus_addr_router #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] S0_BASE     = bus_pkg::S0_BASE,
  parameter logic [ADDR_W-1:0] S1_BASE     = bus_pkg::S1_BASE,
  parameter logic [ADDR_W-1:0] REGION_SIZE = bus_pkg::REGION_SIZE,
  parameter int                TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  input  logic              m_wr_en,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_ready,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_resp,
  output logic              s0_valid,
  output logic              s0_wr_en,
  output logic [ADDR_W-1:0] s0_addr,
  output logic [DATA_W-1:0] s0_wdata,
  input  logic              s0_ready,
  input  logic [DATA_W-1:0] s0_rdata,
  input  logic              s0_resp,
  output logic              s1_valid,
  output logic              s1_wr_en,
  output logic [ADDR_W-1:0] s1_addr,
  output logic [DATA_W-1:0] s1_wdata,
  input  logic              s1_ready,
  input  logic [DATA_W-1:0] s1_rdata,
  input  logic              s1_resp
);
  import bus_pkg::*;

  localparam int             CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  router_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  sel_t             sel_reg, sel_next;
  logic             wr_reg, wr_next;

  logic [1:0]              s_valid_reg, s_valid_next;
  logic [1:0]              s_wr_en_reg, s_wr_en_next;
  logic [1:0][ADDR_W-1:0]  s_addr_reg, s_addr_next;
  logic [1:0][DATA_W-1:0]  s_wdata_reg, s_wdata_next;

  logic              m_ready_reg, m_ready_next;
  logic [DATA_W-1:0] m_rdata_reg, m_rdata_next;
  logic              m_resp_reg, m_resp_next;

  logic              dec_hit;
  sel_t              dec_sel;
  logic              dec_idx;
  logic              slave_ready;
  logic [DATA_W-1:0] slave_rdata;
  logic              slave_resp;

  bus_addr_decode #(
    .ADDR_W (ADDR_W),
    .NUM    (2),
    .BASES  ({S1_BASE, S0_BASE}),
    .SIZE   (REGION_SIZE)
  ) u_decode (
    .addr (m_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign dec_idx     = (dec_sel == SEL_S1);
  assign slave_ready = (sel_reg == SEL_S1) ? s1_ready : s0_ready;
  assign slave_rdata = (sel_reg == SEL_S1) ? s1_rdata : s0_rdata;
  assign slave_resp  = (sel_reg == SEL_S1) ? s1_resp  : s0_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sel_reg     <= SEL_NONE;
      wr_reg      <= 1'b0;
      s_valid_reg <= '0;
      s_wr_en_reg <= '0;
      s_addr_reg  <= '0;
      s_wdata_reg <= '0;
      m_ready_reg <= 1'b0;
      m_rdata_reg <= '0;
      m_resp_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sel_reg     <= sel_next;
      wr_reg      <= wr_next;
      s_valid_reg <= s_valid_next;
      s_wr_en_reg <= s_wr_en_next;
      s_addr_reg  <= s_addr_next;
      s_wdata_reg <= s_wdata_next;
      m_ready_reg <= m_ready_next;
      m_rdata_reg <= m_rdata_next;
      m_resp_reg  <= m_resp_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    sel_next     = sel_reg;
    wr_next      = wr_reg;
    s_valid_next = s_valid_reg;
    s_wr_en_next = s_wr_en_reg;
    s_addr_next  = s_addr_reg;
    s_wdata_next = s_wdata_reg;
    m_ready_next = 1'b0;
    m_rdata_next = m_rdata_reg;
    m_resp_next  = m_resp_reg;

    case (state_reg)
      IDLE: begin
        if (m_valid) begin
          wr_next  = m_wr_en;
          cnt_next = '0;
          if (dec_hit) begin
            sel_next              = dec_sel;
            s_valid_next[dec_idx] = 1'b1;
            s_wr_en_next[dec_idx] = m_wr_en;
            s_addr_next[dec_idx]  = m_addr;
            s_wdata_next[dec_idx] = m_wdata;
            state_next            = FWD;
          end else begin
            sel_next   = SEL_NONE;
            state_next = ERR;
          end
        end
      end
      FWD: begin
        cnt_next = cnt_reg + 1'b1;
        // Ready is checked first so a response on the timeout edge is still honoured.
        if (slave_ready) begin
          s_valid_next = '0;
          m_rdata_next = wr_reg ? '0 : slave_rdata;
          m_resp_next  = slave_resp;
          m_ready_next = 1'b1;
          state_next   = DONE;
        end else if (cnt_reg == TO_LAST) begin
          s_valid_next = '0;
          m_rdata_next = '0;
          m_resp_next  = RESP_ERR;
          m_ready_next = 1'b1;
          state_next   = DONE;
        end
      end
      ERR: begin
        m_rdata_next = '0;
        m_resp_next  = RESP_ERR;
        m_ready_next = 1'b1;
        state_next   = DONE;
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_ready  = m_ready_reg;
  assign m_rdata  = m_rdata_reg;
  assign m_resp   = m_resp_reg;
  assign s0_valid = s_valid_reg[0];
  assign s0_wr_en = s_wr_en_reg[0];
  assign s0_addr  = s_addr_reg[0];
  assign s0_wdata = s_wdata_reg[0];
  assign s1_valid = s_valid_reg[1];
  assign s1_wr_en = s_wr_en_reg[1];
  assign s1_addr  = s_addr_reg[1];
  assign s1_wdata = s_wdata_reg[1];

endmodule

// File: tb/tb_bus_addr_router.sv
// Scoreboard bench for bus_addr_router: behavioural slaves with programmable delay,
// expected completions queued at issue and compared on each m_ready pulse.
module tb_bus_addr_router;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_valid = 1'b0, m_wr_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_ready, m_resp;
  logic [DW-1:0] m_rdata;
  logic          s0_valid, s0_wr_en, s1_valid, s1_wr_en;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [DW-1:0] s0_wdata, s1_wdata;
  logic          s0_ready = 1'b0, s0_resp = 1'b0, s1_ready = 1'b0, s1_resp = 1'b0;
  logic [DW-1:0] s0_rdata = '0, s1_rdata = '0;

  always #5 clk = ~clk;

  bus_addr_router dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_resp(m_resp),
    .s0_valid(s0_valid), .s0_wr_en(s0_wr_en), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_ready(s0_ready), .s0_rdata(s0_rdata), .s0_resp(s0_resp),
    .s1_valid(s1_valid), .s1_wr_en(s1_wr_en), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_ready(s1_ready), .s1_rdata(s1_rdata), .s1_resp(s1_resp)
  );

  typedef struct {
    int            sel;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          resp;
    int            vcyc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int vcount = 0;

  int   dly = 0;
  bit   hang = 1'b0;
  logic sresp = 1'b0;
  int   vc0 = 0, vc1 = 0;
  logic [DW-1:0] mem [2][256];
  logic [DW-1:0] ref_mem [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slaves: ready after dly valid cycles unless hanging.
  always @(negedge clk) begin
    if (s0_valid) begin
      if (!hang && vc0 == dly) begin
        s0_ready = 1'b1; s0_rdata = mem[0][s0_addr]; s0_resp = sresp;
      end
      vc0++;
    end else begin
      vc0 = 0; s0_ready = 1'b0;
    end
    if (s1_valid) begin
      if (!hang && vc1 == dly) begin
        s1_ready = 1'b1; s1_rdata = mem[1][s1_addr]; s1_resp = sresp;
      end
      vc1++;
    end else begin
      vc1 = 0; s1_ready = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (s0_valid && s0_ready && s0_wr_en) mem[0][s0_addr] <= s0_wdata;
    if (s1_valid && s1_ready && s1_wr_en) mem[1][s1_addr] <= s1_wdata;
  end

  // Monitor: slave-side request checks every valid cycle, completion checks on m_ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      vcount = 0;
    end else begin
      if (s0_valid || s1_valid) begin
        vcount++;
        if (sb.size() == 0) begin
          check("unexpected_valid", {s1_valid, s0_valid}, 2'b00);
        end else begin
          e = sb[0];
          check("valid_sel", {s1_valid, s0_valid},
                (e.sel == 0) ? 2'b01 : (e.sel == 1) ? 2'b10 : 2'b00);
          check("s_addr", s1_valid ? s1_addr : s0_addr, e.addr);
          check("s_wr_en", s1_valid ? s1_wr_en : s0_wr_en, e.wr);
          check("s_wdata", s1_valid ? s1_wdata : s0_wdata, e.wdata);
        end
      end
      if (m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", m_ready, 1'b0);
        end else begin
          e = sb.pop_front();
          check("m_rdata", m_rdata, e.rdata);
          check("m_resp", m_resp, e.resp);
          check("valid_cycles", vcount, e.vcyc);
          check("latency", cyc - acc_cyc, e.lat);
          $display("txn wr=%0d addr=%02h wdata=%08h -> resp=%0d rdata=%08h lat=%0d",
                   e.wr, e.addr, e.wdata, m_resp, m_rdata, cyc - acc_cyc);
        end
        vcount = 0;
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int d, input bit hg, input logic srsp, input exp_t e);
    @(negedge clk);
    dly = d; hang = hg; sresp = srsp;
    sb.push_back(e);
    m_valid = 1'b1; m_wr_en = wr; m_addr = addr; m_wdata = wdata;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    m_valid = 1'b0;
  endtask

  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int d, input bit hg, input logic srsp);
    exp_t e;
    bit   to;
    e.sel   = (addr < 8'h40) ? 0 : (addr < 8'h80) ? 1 : 2;
    to      = (e.sel != 2) && (hg || d >= 16);
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    if (e.sel == 2 || to) begin
      e.rdata = '0; e.resp = 1'b1;
    end else begin
      e.rdata = wr ? '0 : ref_mem[addr]; e.resp = srsp;
    end
    e.vcyc = (e.sel == 2) ? 0 : to ? 16 : d + 1;
    e.lat  = (e.sel == 2) ? 1 : to ? 16 : d + 1;
    if (wr && e.sel != 2 && !to) ref_mem[addr] = wdata;
    issue(wr, addr, wdata, d, hg, srsp, e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    check("completion", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = '0; mem[1][i] = '0; ref_mem[i] = '0;
    end

    #2;
    check("rst_m_ready", m_ready, 1'b0);
    check("rst_m_rdata", m_rdata, '0);
    check("rst_m_resp", m_resp, 1'b0);
    check("rst_s_valid", {s1_valid, s0_valid}, 2'b00);
    check("rst_s_req", {s0_wr_en, s0_addr, s1_wr_en, s1_addr}, '0);
    check("rst_s_wdata", {s0_wdata, s1_wdata}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    xfer(1'b1, 8'h10, 32'hAAAA_BBBB, 1, 1'b0, 1'b0);
    xfer(1'b1, 8'h50, 32'hCCCC_DDDD, 0, 1'b0, 1'b0);
    xfer(1'b0, 8'h10, '0, 0, 1'b0, 1'b0);
    xfer(1'b0, 8'h50, '0, 2, 1'b0, 1'b0);

    xfer(1'b0, 8'h3F, '0, 0, 1'b0, 1'b0);
    xfer(1'b0, 8'h40, '0, 0, 1'b0, 1'b0);
    xfer(1'b0, 8'h7F, '0, 0, 1'b0, 1'b0);
    xfer(1'b0, 8'h80, '0, 0, 1'b0, 1'b0);
    xfer(1'b1, 8'hFF, 32'h1234_5678, 0, 1'b0, 1'b0);

    xfer(1'b0, 8'h44, '0, 0, 1'b1, 1'b0);
    xfer(1'b0, 8'h44, '0, 0, 1'b0, 1'b0);
    xfer(1'b0, 8'h10, '0, 15, 1'b0, 1'b0);
    xfer(1'b0, 8'h50, '0, 1, 1'b0, 1'b1);

    for (int n = 0; n < 12; n++) begin
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom,
           $urandom_range(0, 3), 1'b0, 1'b0);
    end

    // Reset while a read of 0x10 is stuck waiting on slave 0.
    e.sel = 0; e.wr = 1'b0; e.addr = 8'h10; e.wdata = '0;
    e.rdata = '0; e.resp = 1'b0; e.vcyc = 0; e.lat = 0;
    issue(1'b0, 8'h10, '0, 0, 1'b1, 1'b0, e);
    repeat (3) @(negedge clk);
    #2;
    check("mid_fwd_s0_valid", s0_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_s0_valid", s0_valid, 1'b0);
    check("async_rst_m_ready", m_ready, 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    repeat (4) @(negedge clk);
    xfer(1'b0, 8'h10, '0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
